// File: rtl/riscv_ifu_align.sv
// Instruction fetch/align stage: issues word fetches, buffers 16-bit parcels and
// presents one aligned 16- or 32-bit instruction with its PC to the decoder.
module riscv_ifu_align #(
  parameter logic [31:0] PC_RST  = 32'h0000_0000,
  parameter int unsigned BUF     = 4,
  parameter int unsigned OUT_MAX = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_vld,
  output logic [31:0] if_req_adr,
  input  logic        if_req_rdy,
  input  logic        if_rsp_vld,
  input  logic [31:0] if_rsp_dat,
  output logic        if_rsp_rdy,
  input  logic        jmp_vld,
  input  logic [31:0] jmp_adr,
  output logic        id_vld,
  output logic [31:0] id_ins,
  output logic [2:0]  id_siz,
  output logic [31:0] id_pc,
  input  logic        id_rdy
);

  localparam int unsigned CW = $clog2(BUF + 1);
  localparam int unsigned OW = $clog2(OUT_MAX + 1);
  localparam logic [OW-1:0] OUT_MAX_W = OW'(OUT_MAX);

  // Handshakes: a transfer happens on a rising edge where vld and rdy are both 1;
  // vld never waits for rdy, and the payload holds while vld=1 and rdy=0.

  logic [16*BUF-1:0] pq, pq_sh, pq_n;
  logic [CW-1:0]     cnt, cnt_sh, cnt_n;
  logic [OW-1:0]     outs, outs_n, drop;
  logic [31:0]       fetch_adr, pc;
  logic              skip, run;

  logic [15:0] p0, p1;
  logic        is32, consume, req_hs, rsp_hs, room, app;

  assign p0   = pq[15:0];
  assign p1   = pq[31:16];
  assign is32 = (p0[1:0] == 2'b11);

  assign id_vld = is32 ? (cnt >= CW'(2)) : (cnt >= CW'(1));
  assign id_ins = !id_vld ? 32'h0 : (is32 ? {p1, p0} : {16'h0, p0});
  assign id_siz = (id_vld && is32) ? 3'd4 : 3'd2;
  assign id_pc  = pc;

  // Only issue a request when every outstanding response is guaranteed a slot.
  assign room       = (32'(cnt) + (32'(outs) << 1) + 32'd2) <= BUF;
  assign if_req_vld = run && (outs < OUT_MAX_W) && room;
  assign if_req_adr = fetch_adr;
  assign if_rsp_rdy = run;

  assign consume = id_vld && id_rdy;
  assign req_hs  = if_req_vld && if_req_rdy;
  assign rsp_hs  = if_rsp_vld && run;
  assign app     = rsp_hs && !jmp_vld && (drop == '0);
  assign outs_n  = outs + OW'(req_hs) - OW'(rsp_hs);

  always_comb begin
    pq_sh  = pq;
    cnt_sh = cnt;
    if (consume) begin
      if (is32) begin
        pq_sh  = pq >> 32;
        cnt_sh = cnt - CW'(2);
      end else begin
        pq_sh  = pq >> 16;
        cnt_sh = cnt - CW'(1);
      end
    end
    pq_n  = pq_sh;
    cnt_n = cnt_sh;
    // New parcels land behind whatever survives this cycle's consume.
    if (app) begin
      for (int unsigned i = 0; i < BUF; i++) begin
        if (skip) begin
          if (i == 32'(cnt_sh)) pq_n[16*i +: 16] = if_rsp_dat[31:16];
        end else begin
          if (i == 32'(cnt_sh))         pq_n[16*i +: 16] = if_rsp_dat[15:0];
          if (i == 32'(cnt_sh) + 32'd1) pq_n[16*i +: 16] = if_rsp_dat[31:16];
        end
      end
      cnt_n = cnt_sh + (skip ? CW'(1) : CW'(2));
    end
    if (jmp_vld) cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq        <= '0;
      cnt       <= '0;
      outs      <= '0;
      drop      <= '0;
      fetch_adr <= {PC_RST[31:2], 2'b00};
      pc        <= {PC_RST[31:1], 1'b0};
      skip      <= PC_RST[1];
      run       <= 1'b0;
    end else begin
      run  <= 1'b1;
      pq   <= pq_n;
      cnt  <= cnt_n;
      outs <= outs_n;
      if (jmp_vld) begin
        // Everything still in flight after this edge belongs to the old stream.
        drop      <= outs_n;
        skip      <= jmp_adr[1];
        fetch_adr <= {jmp_adr[31:2], 2'b00};
        pc        <= {jmp_adr[31:1], 1'b0};
      end else begin
        if (rsp_hs && drop != '0) drop <= drop - OW'(1);
        if (app && skip)          skip <= 1'b0;
        if (req_hs)               fetch_adr <= fetch_adr + 32'd4;
        if (consume)              pc <= pc + {29'b0, id_siz};
      end
    end
  end

endmodule

// File: tb/tb_riscv_ifu_align.sv
// Directed bench for riscv_ifu_align: in-order memory model with programmable
// latency, redirects, decoder stall and mid-stream reset.
module tb_riscv_ifu_align;

  logic        clk;
  logic        rst_n;
  logic        if_req_vld;
  logic [31:0] if_req_adr;
  logic        if_req_rdy;
  logic        if_rsp_vld;
  logic [31:0] if_rsp_dat;
  logic        if_rsp_rdy;
  logic        jmp_vld;
  logic [31:0] jmp_adr;
  logic        id_vld;
  logic [31:0] id_ins;
  logic [2:0]  id_siz;
  logic [31:0] id_pc;
  logic        id_rdy;

  riscv_ifu_align #(.PC_RST(32'h0000_0080), .BUF(4), .OUT_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_vld(if_req_vld), .if_req_adr(if_req_adr), .if_req_rdy(if_req_rdy),
    .if_rsp_vld(if_rsp_vld), .if_rsp_dat(if_rsp_dat), .if_rsp_rdy(if_rsp_rdy),
    .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
    .id_vld(id_vld), .id_ins(id_ins), .id_siz(id_siz), .id_pc(id_pc), .id_rdy(id_rdy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mq_adr[$];
  int          mq_t[$];
  int          lat = 1;
  int          cyc = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[13:0], 2'b11};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return word(a);
  endfunction

  initial begin
    if_req_rdy = 1'b1;
    if_rsp_vld = 1'b0;
    if_rsp_dat = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mq_adr.delete();
        mq_t.delete();
        if_rsp_vld = 1'b0;
      end else begin
        if_rsp_vld = 1'b0;
        if (if_rsp_rdy && mq_t.size() > 0 && mq_t[0] <= cyc) begin
          if_rsp_vld = 1'b1;
          if_rsp_dat = mem_rd(mq_adr.pop_front());
          void'(mq_t.pop_front());
        end
        if (if_req_vld && if_req_rdy) begin
          mq_adr.push_back(if_req_adr);
          mq_t.push_back(cyc + lat);
        end
      end
    end
  end

  // scoreboard
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic take_id(input string tag, input logic [31:0] epc,
                         input logic [31:0] eins, input logic [31:0] esiz);
    int w = 0;
    while (!id_vld && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!id_vld) begin
      check({tag, "_timeout"}, 32'(id_vld), 32'd1);
    end else begin
      check({tag, "_pc"}, id_pc, epc);
      check({tag, "_ins"}, id_ins, eins);
      check({tag, "_siz"}, 32'(id_siz), esiz);
      @(negedge clk);
    end
  endtask

  task automatic jump(input logic [31:0] a);
    jmp_vld = 1'b1;
    jmp_adr = a;
    @(negedge clk);
    jmp_vld = 1'b0;
  endtask

  task automatic wait_pending(input string tag, input int n);
    int w = 0;
    while (mq_t.size() < n && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_pending"}, 32'(mq_t.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_vld"}, 32'(if_req_vld), 32'd0);
    check({tag, "_rsp_rdy"}, 32'(if_rsp_rdy), 32'd0);
    check({tag, "_id_vld"}, 32'(id_vld), 32'd0);
    check({tag, "_id_ins"}, id_ins, 32'h0);
    check({tag, "_id_siz"}, 32'(id_siz), 32'd2);
    check({tag, "_id_pc"}, id_pc, 32'h0000_0080);
    check({tag, "_req_adr"}, if_req_adr, 32'h0000_0080);
  endtask

  initial begin
    rst_n   = 1'b0;
    jmp_vld = 1'b0;
    jmp_adr = 32'h0;
    id_rdy  = 1'b1;
    mem[32'h0000_0000] = 32'h0513_4501;
    mem[32'h0000_0004] = 32'h1234_0000;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: sequential 32-bit ops from PC_RST, 1-cycle memory
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h80 + 32'(4 * i));
    while (exp_q.size() > 0) begin
      logic [31:0] p;
      p = exp_q.pop_front();
      take_id("seq", p, word(p), 32'd4);
    end

    // 2: compressed op then a 32-bit op straddling the word boundary
    jump(32'h0000_0000);
    take_id("c16", 32'h0, 32'h0000_4501, 32'd2);
    take_id("strad", 32'h2, 32'h0000_0513, 32'd4);
    take_id("c16b", 32'h6, 32'h0000_1234, 32'd2);
    take_id("after", 32'h8, 32'h0008_0023, 32'd4);

    // 3: redirect to halfword address drops the low parcel
    jump(32'h0000_0102);
    check("jmp_adr", if_req_adr, 32'h0000_0100);
    take_id("j102", 32'h102, 32'h0000_0100, 32'd2);
    take_id("j104", 32'h104, 32'h0104_0413, 32'd4);

    // 4: redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    jump(32'h0000_0200);
    wait_pending("out2", 2);
    jump(32'h0000_0300);
    take_id("j300", 32'h300, 32'h0300_0c03, 32'd4);
    take_id("j304", 32'h304, 32'h0304_0c13, 32'd4);

    // 5: decoder stall fills the buffer, then drains in order
    lat = 1;
    id_rdy = 1'b0;
    jump(32'h0000_0400);
    repeat (5) @(negedge clk);
    check("stall5_vld", 32'(id_vld), 32'd1);
    check("stall5_ins", id_ins, 32'h0400_1003);
    repeat (5) @(negedge clk);
    check("stall10_ins", id_ins, 32'h0400_1003);
    check("stall10_pc", id_pc, 32'h0000_0400);
    check("stall10_siz", 32'(id_siz), 32'd4);
    check("stall10_req", 32'(if_req_vld), 32'd0);
    id_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = 32'h400 + 32'(4 * i);
      take_id("drain", p, word(p), 32'd4);
    end

    // 6: reset mid-stream with requests outstanding
    lat = 3;
    jump(32'h0000_0500);
    wait_pending("pre_rst", 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    lat = 1;
    rst_n = 1'b1;
    take_id("re80", 32'h80, 32'h0080_0203, 32'd4);
    take_id("re84", 32'h84, 32'h0084_0213, 32'd4);
    take_id("re88", 32'h88, 32'h0088_0223, 32'd4);

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
